// File: rtl/sdram_address_sequencer.sv
// Write/read circular-buffer pointers, occupancy and status flags for the SDRAM stream buffer.
// Optional build macro ADDR_SEQ_OVERWRITE_EN: a write into a full buffer discards the oldest word.
module sdram_address_sequencer #(
    parameter int unsigned INIT_CYCLES  = 4800,
    parameter logic [23:0] LAST_ADDR    = 24'hFFFFFF,
    parameter logic [23:0] AFULL_THRESH = 24'hF00000
) (
    input  logic        CLK_48MHZ,
    input  logic        RESET,
    input  logic        NEXT_WRITE,
    input  logic        NEXT_READ,
    input  logic        CLEAR,
    output logic [1:0]  BA_WRITE,
    output logic [12:0] ROW_WRITE,
    output logic [8:0]  COL_WRITE,
    output logic [1:0]  BA_READ,
    output logic [12:0] ROW_READ,
    output logic [8:0]  COL_READ,
    output logic [24:0] COUNT,
    output logic        EMPTY,
    output logic        FULL,
    output logic        ALMOST_FULL,
    output logic        READY,
    output logic        OVERFLOW,
    output logic        UNDERFLOW
);

    localparam logic [24:0] DEPTH     = {1'b0, LAST_ADDR} + 25'd1;
    localparam logic [24:0] AFULL_CNT = {1'b0, AFULL_THRESH};
    localparam logic [31:0] INIT_LOAD = INIT_CYCLES;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] init_cnt_q, init_cnt_d;
    logic [23:0] wr_ptr_q, wr_ptr_d;
    logic [23:0] rd_ptr_q, rd_ptr_d;
    logic [24:0] count_q, count_d;
    logic        empty_q, empty_d;
    logic        full_q, full_d;
    logic        afull_q, afull_d;
    logic        ready_q, ready_d;
    logic        ovf_q, ovf_d;
    logic        unf_q, unf_d;
    logic        nw_q, nw_d;
    logic        nr_q, nr_d;
    logic        wr_ev, rd_ev;

    function automatic logic [23:0] ptr_inc(input logic [23:0] p);
        return (p == LAST_ADDR) ? 24'd0 : p + 24'd1;
    endfunction

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        unf_d      = unf_q;
        nw_d       = NEXT_WRITE;
        nr_d       = NEXT_READ;
        wr_ev      = NEXT_WRITE & ~nw_q;
        rd_ev      = NEXT_READ & ~nr_q;

        case (state_q)
            ST_INIT: begin
                if (init_cnt_q == 32'd0) begin
                    state_d = ST_RUN;
                end else begin
                    init_cnt_d = init_cnt_q - 32'd1;
                end
            end

            ST_RUN: begin
                if (CLEAR) begin
                    state_d = ST_FLUSH;
                end
                if (wr_ev && rd_ev) begin
                    if (empty_q) begin
                        // Nothing to read yet: the read is lost, the write still lands.
                        wr_ptr_d = ptr_inc(wr_ptr_q);
                        count_d  = count_q + 25'd1;
                        unf_d    = 1'b1;
                    end else begin
                        wr_ptr_d = ptr_inc(wr_ptr_q);
                        rd_ptr_d = ptr_inc(rd_ptr_q);
                    end
                end else if (wr_ev) begin
                    if (!full_q) begin
                        wr_ptr_d = ptr_inc(wr_ptr_q);
                        count_d  = count_q + 25'd1;
                    end else begin
                        ovf_d = 1'b1;
`ifdef ADDR_SEQ_OVERWRITE_EN
                        wr_ptr_d = ptr_inc(wr_ptr_q);
                        rd_ptr_d = ptr_inc(rd_ptr_q);
`endif
                    end
                end else if (rd_ev) begin
                    if (!empty_q) begin
                        rd_ptr_d = ptr_inc(rd_ptr_q);
                        count_d  = count_q - 25'd1;
                    end else begin
                        unf_d = 1'b1;
                    end
                end
            end

            ST_FLUSH: begin
                wr_ptr_d = 24'd0;
                rd_ptr_d = 24'd0;
                count_d  = 25'd0;
                ovf_d    = 1'b0;
                unf_d    = 1'b0;
                state_d  = ST_RUN;
            end

            default: begin
                state_d = ST_INIT;
            end
        endcase

        // Flags follow the next-state count so they never lag COUNT.
        empty_d = (count_d == 25'd0);
        full_d  = (count_d == DEPTH);
        afull_d = (count_d >= AFULL_CNT);
        ready_d = (state_d == ST_RUN);
    end

    always_ff @(posedge CLK_48MHZ or negedge RESET) begin
        if (!RESET) begin
            state_q    <= ST_INIT;
            init_cnt_q <= INIT_LOAD;
            wr_ptr_q   <= 24'd0;
            rd_ptr_q   <= 24'd0;
            count_q    <= 25'd0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            afull_q    <= 1'b0;
            ready_q    <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            nw_q       <= 1'b0;
            nr_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            afull_q    <= afull_d;
            ready_q    <= ready_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            nw_q       <= nw_d;
            nr_q       <= nr_d;
        end
    end

    assign BA_WRITE    = wr_ptr_q[23:22];
    assign ROW_WRITE   = wr_ptr_q[21:9];
    assign COL_WRITE   = wr_ptr_q[8:0];
    assign BA_READ     = rd_ptr_q[23:22];
    assign ROW_READ    = rd_ptr_q[21:9];
    assign COL_READ    = rd_ptr_q[8:0];
    assign COUNT       = count_q;
    assign EMPTY       = empty_q;
    assign FULL        = full_q;
    assign ALMOST_FULL = afull_q;
    assign READY       = ready_q;
    assign OVERFLOW    = ovf_q;
    assign UNDERFLOW   = unf_q;

endmodule

// File: tb/tb_sdram_address_sequencer.sv
// Directed bench for sdram_address_sequencer: a small 16-word buffer plus a full-size instance for field mapping.
module tb_sdram_address_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        nw, nr, clr, nw2;

    logic [1:0]  ba_w, ba_r, b_ba_w, b_ba_r;
    logic [12:0] row_w, row_r, b_row_w, b_row_r;
    logic [8:0]  col_w, col_r, b_col_w, b_col_r;
    logic [24:0] count, b_count;
    logic        empty, full, afull, ready, ovf, unf;
    logic        b_empty, b_full, b_afull, b_ready, b_ovf, b_unf;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    sdram_address_sequencer #(
        .INIT_CYCLES (8),
        .LAST_ADDR   (24'h00000F),
        .AFULL_THRESH(24'h00000C)
    ) dut (
        .CLK_48MHZ  (clk),
        .RESET      (rst_n),
        .NEXT_WRITE (nw),
        .NEXT_READ  (nr),
        .CLEAR      (clr),
        .BA_WRITE   (ba_w),
        .ROW_WRITE  (row_w),
        .COL_WRITE  (col_w),
        .BA_READ    (ba_r),
        .ROW_READ   (row_r),
        .COL_READ   (col_r),
        .COUNT      (count),
        .EMPTY      (empty),
        .FULL       (full),
        .ALMOST_FULL(afull),
        .READY      (ready),
        .OVERFLOW   (ovf),
        .UNDERFLOW  (unf)
    );

    sdram_address_sequencer #(
        .INIT_CYCLES (0),
        .LAST_ADDR   (24'hFFFFFF),
        .AFULL_THRESH(24'hF00000)
    ) u_big (
        .CLK_48MHZ  (clk),
        .RESET      (rst_n),
        .NEXT_WRITE (nw2),
        .NEXT_READ  (1'b0),
        .CLEAR      (1'b0),
        .BA_WRITE   (b_ba_w),
        .ROW_WRITE  (b_row_w),
        .COL_WRITE  (b_col_w),
        .BA_READ    (b_ba_r),
        .ROW_READ   (b_row_r),
        .COL_READ   (b_col_r),
        .COUNT      (b_count),
        .EMPTY      (b_empty),
        .FULL       (b_full),
        .ALMOST_FULL(b_afull),
        .READY      (b_ready),
        .OVERFLOW   (b_ovf),
        .UNDERFLOW  (b_unf)
    );

    wire [31:0] wptr = {8'h00, ba_w, row_w, col_w};
    wire [31:0] rptr = {8'h00, ba_r, row_r, col_r};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr_pulse();
        nw = 1'b1;
        tick();
        nw = 1'b0;
        tick();
    endtask

    task automatic rd_pulse();
        nr = 1'b1;
        tick();
        nr = 1'b0;
        tick();
    endtask

    task automatic clear_pulse();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        tick();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        nw    = 1'b0;
        nr    = 1'b0;
        clr   = 1'b0;
        nw2   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(ready), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_afull", 32'(afull), 0);
        chk("rst_ovf", 32'(ovf), 0);
        chk("rst_unf", 32'(unf), 0);
        chk("rst_wptr", wptr, 0);
        chk("rst_rptr", rptr, 0);

        // Power-up window: write pulses are ignored for 8 clocks.
        rst_n = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            nw = (i % 2 == 1);
            tick();
            chk("init_ready", 32'(ready), 0);
            chk("init_wptr", wptr, 0);
            chk("init_count", 32'(count), 0);
        end
        nw = 1'b0;
        tick();
        chk("run_ready", 32'(ready), 1);
        chk("run_wptr", wptr, 0);

        // A level held high counts once.
        nw = 1'b1;
        tick();
        chk("hold_col1", 32'(col_w), 1);
        chk("hold_count1", 32'(count), 1);
        chk("hold_empty", 32'(empty), 0);
        repeat (4) tick();
        chk("hold_col_after", 32'(col_w), 1);
        chk("hold_count_after", 32'(count), 1);
        nw = 1'b0;
        tick();

        clear_pulse();
        chk("clr1_wptr", wptr, 0);
        chk("clr1_count", 32'(count), 0);
        chk("clr1_empty", 32'(empty), 1);

        // Lone read at empty.
        nr = 1'b1;
        tick();
        chk("rd_empty_unf", 32'(unf), 1);
        chk("rd_empty_rptr", rptr, 0);
        chk("rd_empty_count", 32'(count), 0);
        nr = 1'b0;
        tick();
        clear_pulse();
        chk("clr2_unf", 32'(unf), 0);

        // Simultaneous read and write at empty.
        nw = 1'b1;
        nr = 1'b1;
        tick();
        chk("both_empty_unf", 32'(unf), 1);
        chk("both_empty_count", 32'(count), 1);
        chk("both_empty_rptr", rptr, 0);
        chk("both_empty_wptr", wptr, 1);
        chk("both_empty_empty", 32'(empty), 0);
        nw = 1'b0;
        nr = 1'b0;
        tick();
        clear_pulse();

        // Fill to 16 words.
        for (int k = 1; k <= 16; k++) begin
            wr_pulse();
            chk("fill_count", 32'(count), 32'(k));
            chk("fill_afull", 32'(afull), (k >= 12) ? 1 : 0);
            chk("fill_full", 32'(full), (k == 16) ? 1 : 0);
        end
        chk("full_wptr", wptr, 0);
        chk("full_rptr", rptr, 0);
        chk("full_empty", 32'(empty), 0);

        wr_pulse();
        chk("ovf_flag", 32'(ovf), 1);
        chk("ovf_count", 32'(count), 16);
        chk("ovf_full", 32'(full), 1);
`ifdef ADDR_SEQ_OVERWRITE_EN
        chk("ovf_wptr", wptr, 1);
        chk("ovf_rptr", rptr, 1);
`else
        chk("ovf_wptr", wptr, 0);
        chk("ovf_rptr", rptr, 0);
`endif

        // Simultaneous read and write while full.
        nw = 1'b1;
        nr = 1'b1;
        tick();
        nw = 1'b0;
        nr = 1'b0;
        tick();
        chk("both_full_count", 32'(count), 16);
        chk("both_full_full", 32'(full), 1);
`ifdef ADDR_SEQ_OVERWRITE_EN
        chk("both_full_wptr", wptr, 2);
        chk("both_full_rptr", rptr, 2);
`else
        chk("both_full_wptr", wptr, 1);
        chk("both_full_rptr", rptr, 1);
`endif

        for (int k = 0; k < 11; k++) rd_pulse();
        chk("drain_count", 32'(count), 5);
        chk("drain_afull", 32'(afull), 0);
        chk("drain_full", 32'(full), 0);
        chk("drain_ovf", 32'(ovf), 1);
`ifdef ADDR_SEQ_OVERWRITE_EN
        chk("drain_rptr", rptr, 13);
`else
        chk("drain_rptr", rptr, 12);
`endif

        // Flush with COUNT=5 and OVERFLOW set.
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("flush_ready", 32'(ready), 0);
        tick();
        chk("flush_wptr", wptr, 0);
        chk("flush_rptr", rptr, 0);
        chk("flush_count", 32'(count), 0);
        chk("flush_empty", 32'(empty), 1);
        chk("flush_ovf", 32'(ovf), 0);
        chk("flush_unf", 32'(unf), 0);
        chk("flush_full", 32'(full), 0);
        chk("flush_ready_back", 32'(ready), 1);

        // Asynchronous reset in the middle of a write burst.
        wr_pulse();
        wr_pulse();
        wr_pulse();
        chk("burst_count", 32'(count), 3);
        nw = 1'b1;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ready", 32'(ready), 0);
        chk("arst_count", 32'(count), 0);
        chk("arst_wptr", wptr, 0);
        chk("arst_empty", 32'(empty), 1);
        nw = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("rerun_ready", 32'(ready), 0);

        // Field mapping on the full-size instance.
        for (int k = 0; k < 511; k++) begin
            nw2 = 1'b1;
            tick();
            nw2 = 1'b0;
            tick();
        end
        chk("big_col_1ff", 32'(b_col_w), 32'h1FF);
        chk("big_row_0", 32'(b_row_w), 0);
        chk("big_count", 32'(b_count), 32'h1FF);
        nw2 = 1'b1;
        tick();
        nw2 = 1'b0;
        tick();
        chk("big_col_wrap", 32'(b_col_w), 0);
        chk("big_row_1", 32'(b_row_w), 1);
        chk("big_ba_0", 32'(b_ba_w), 0);
        chk("big_count2", 32'(b_count), 32'h200);
        chk("big_rptr", {8'h00, b_ba_r, b_row_r, b_col_r}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
